multi_channel_interval_timer: RTL and testbench

Parametrised N-channel interval timer with an Avalon-MM slave port, the next-generation system timer for the MSoC platform. Each channel has a CNT_W-bit down-counter, a programmable prescaler, one-shot/continuous mode, snapshot capture, a PWM compare output and its own interrupt. Per-channel IRQs are OR-reduced onto a single `irq` line for the Nios II interrupt controller. The per-channel state vector `irq_vec` is also exported so the CPU can find the source without polling.

---
 rtl/multi_channel_interval_timer.sv | 136 +++++++++++++
 tb/tb_multi_channel_interval_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_interval_timer.sv
// N-channel interval timer with Avalon-MM slave port: per-channel prescaled down-counter,
// one-shot/continuous mode, snapshot capture, PWM compare output and interrupt.
module multi_channel_interval_timer #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PRE_W        = 8,
    parameter int unsigned RESET_PERIOD = 49999,
    localparam int unsigned AW          = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec,
    output logic [NUM_CH-1:0] pwm_out
);

    logic [CNT_W-1:0] period_q  [NUM_CH];
    logic [CNT_W-1:0] cnt_q     [NUM_CH];
    logic [CNT_W-1:0] cmp_q     [NUM_CH];
    logic [CNT_W-1:0] snap_q    [NUM_CH];
    logic [PRE_W-1:0] pre_q     [NUM_CH];
    logic [PRE_W-1:0] pre_cnt_q [NUM_CH];

    logic [NUM_CH-1:0] run_q, to_q, ito_q, cont_q, pwm_en_q, pwm_q;
    logic [NUM_CH-1:0] ch_wr, tick, timeout;
    logic [31:0]       readdata_q, rd_mux, sel_ch;
    logic              write_en;

    assign write_en = chipselect & ~write_n;
    assign sel_ch   = 32'(address) >> 3;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_wr[c]   = write_en && (sel_ch == c);
            tick[c]    = run_q[c] && (pre_cnt_q[c] == pre_q[c]);
            timeout[c] = tick[c] && (cnt_q[c] == '0);
        end
    end

    // Out-of-range channels never match, so they read 0.
    always_comb begin
        rd_mux = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (sel_ch == c) begin
                case (address[2:0])
                    3'd0: rd_mux[1:0] = {run_q[c], to_q[c]};
                    3'd1: begin
                        rd_mux[0] = ito_q[c];
                        rd_mux[1] = cont_q[c];
                        rd_mux[4] = pwm_en_q[c];
                    end
                    3'd2: rd_mux[CNT_W-1:0] = period_q[c];
                    3'd3: rd_mux[CNT_W-1:0] = cmp_q[c];
                    3'd4: rd_mux[CNT_W-1:0] = snap_q[c];
                    3'd5: rd_mux[PRE_W-1:0] = pre_q[c];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
            run_q      <= '0;
            to_q       <= '0;
            ito_q      <= '0;
            cont_q     <= '0;
            pwm_en_q   <= '0;
            pwm_q      <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                period_q[c]  <= CNT_W'(RESET_PERIOD);
                cnt_q[c]     <= CNT_W'(RESET_PERIOD);
                cmp_q[c]     <= '0;
                snap_q[c]    <= '0;
                pre_q[c]     <= '0;
                pre_cnt_q[c] <= '0;
            end
        end else begin
            readdata_q <= rd_mux;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (tick[c]) begin
                    pre_cnt_q[c] <= '0;
                    if (cnt_q[c] == '0) begin
                        cnt_q[c] <= period_q[c];
                        if (!cont_q[c]) run_q[c] <= 1'b0;
                    end else begin
                        cnt_q[c] <= cnt_q[c] - CNT_W'(1);
                    end
                end else if (run_q[c]) begin
                    pre_cnt_q[c] <= pre_cnt_q[c] + PRE_W'(1);
                end

                pwm_q[c] <= pwm_en_q[c] & run_q[c] & (cnt_q[c] < cmp_q[c]);

                // Bus writes override the counting update made above in the same edge.
                if (ch_wr[c]) begin
                    case (address[2:0])
                        3'd0: to_q[c] <= 1'b0;
                        3'd1: begin
                            ito_q[c]    <= writedata[0];
                            cont_q[c]   <= writedata[1];
                            pwm_en_q[c] <= writedata[4];
                            if (writedata[2])      run_q[c] <= 1'b1;
                            else if (writedata[3]) run_q[c] <= 1'b0;
                        end
                        3'd2: begin
                            period_q[c]  <= writedata[CNT_W-1:0];
                            cnt_q[c]     <= writedata[CNT_W-1:0];
                            pre_cnt_q[c] <= '0;
                            run_q[c]     <= 1'b0;
                        end
                        3'd3: cmp_q[c]  <= writedata[CNT_W-1:0];
                        3'd4: snap_q[c] <= cnt_q[c];
                        3'd5: pre_q[c]  <= writedata[PRE_W-1:0];
                        default: ;
                    endcase
                end

                // A timeout beats a coincident STATUS clear so no event is lost.
                if (timeout[c]) to_q[c] <= 1'b1;
            end
        end
    end

    assign readdata = readdata_q;
    assign irq_vec  = to_q & ito_q;
    assign irq      = |irq_vec;
    assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Directed and randomized bench for multi_channel_interval_timer, checked against a
// cycle-level behavioural model of the register/timer rules.
module tb_multi_channel_interval_timer;

    localparam int unsigned NCH  = 3;
    localparam int unsigned MASK = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [2:0]  irq_vec;
    logic [2:0]  pwm_out;

    int compared = 0;
    int mismatched = 0;

    multi_channel_interval_timer #(
        .NUM_CH(3),
        .CNT_W(16),
        .PRE_W(8),
        .RESET_PERIOD(49999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .irq_vec(irq_vec),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int unsigned m_period[NCH], m_cnt[NCH], m_cmp[NCH], m_snap[NCH], m_pre[NCH], m_pcnt[NCH];
    bit          m_run[NCH], m_to[NCH], m_ito[NCH], m_cont[NCH], m_pen[NCH], m_pwm[NCH];
    logic [31:0] m_rd;

    function automatic logic [31:0] model_read(int unsigned a);
        int unsigned ch = a >> 3;
        int unsigned r  = a & 7;
        logic [31:0] v  = '0;
        if (ch < NCH) begin
            case (r)
                0: v = {30'b0, m_run[ch], m_to[ch]};
                1: v = {27'b0, m_pen[ch], 2'b00, m_cont[ch], m_ito[ch]};
                2: v = m_period[ch];
                3: v = m_cmp[ch];
                4: v = m_snap[ch];
                5: v = m_pre[ch];
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic model_clock(bit rst, bit cs, bit wn, int unsigned a, logic [31:0] wd);
        int unsigned wch = a >> 3;
        int unsigned wreg = a & 7;
        bit we = cs && !wn && (wch < NCH);
        if (rst) begin
            m_rd = '0;
            for (int c = 0; c < NCH; c++) begin
                m_period[c] = 49999; m_cnt[c] = 49999;
                m_cmp[c] = 0; m_snap[c] = 0; m_pre[c] = 0; m_pcnt[c] = 0;
                m_run[c] = 0; m_to[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
                m_pen[c] = 0; m_pwm[c] = 0;
            end
            return;
        end
        m_rd = model_read(a);
        for (int c = 0; c < NCH; c++) begin
            int unsigned old_cnt = m_cnt[c];
            bit fired = 0;
            m_pwm[c] = m_pen[c] && m_run[c] && (m_cnt[c] < m_cmp[c]);
            if (m_run[c]) begin
                if (m_pcnt[c] == m_pre[c]) begin
                    m_pcnt[c] = 0;
                    if (m_cnt[c] == 0) begin
                        m_cnt[c] = m_period[c];
                        fired = 1;
                        if (!m_cont[c]) m_run[c] = 0;
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end else begin
                    m_pcnt[c] = m_pcnt[c] + 1;
                end
            end
            if (we && wch == c) begin
                case (wreg)
                    0: m_to[c] = 0;
                    1: begin
                        m_ito[c] = wd[0]; m_cont[c] = wd[1]; m_pen[c] = wd[4];
                        if (wd[2]) m_run[c] = 1;
                        else if (wd[3]) m_run[c] = 0;
                    end
                    2: begin
                        m_period[c] = wd & MASK; m_cnt[c] = wd & MASK;
                        m_pcnt[c] = 0; m_run[c] = 0;
                    end
                    3: m_cmp[c] = wd & MASK;
                    4: m_snap[c] = old_cnt;
                    5: m_pre[c] = wd & 32'hFF;
                    default: ;
                endcase
            end
            if (fired) m_to[c] = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit rst, bit cs, bit wn, int unsigned a, logic [31:0] wd);
        logic [2:0] ev, ep;
        reset = rst; chipselect = cs; write_n = wn; address = a[4:0]; writedata = wd;
        model_clock(rst, cs, wn, a, wd);
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            ev[c] = m_to[c] & m_ito[c];
            ep[c] = m_pwm[c];
        end
        check("readdata", readdata, m_rd);
        check("irq_vec", {29'b0, irq_vec}, {29'b0, ev});
        check("irq", {31'b0, irq}, {31'b0, |ev});
        check("pwm_out", {29'b0, pwm_out}, {29'b0, ep});
    endtask

    task automatic wr(int unsigned a, logic [31:0] d);
        step(0, 1, 0, a, d);
    endtask

    task automatic rd(int unsigned a);
        step(0, 0, 1, a, 0);
    endtask

    task automatic idle();
        step(0, 0, 1, 0, 0);
    endtask

    initial begin
        int n;
        int hi;

        // Reset values
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        rd(2);  check("rst_period", readdata, 49999);
        rd(0);  check("rst_status", readdata, 0);
        rd(5);  check("rst_prescale", readdata, 0);
        check("rst_irq", {31'b0, irq}, 0);
        check("rst_pwm", {29'b0, pwm_out}, 0);

        // One-shot on ch0
        wr(2, 5);
        wr(1, 32'h5);
        n = 0;
        while (!irq && n < 20) begin idle(); n++; end
        check("oneshot_latency", n, 6);
        rd(0);  check("oneshot_status", readdata, 1);
        wr(4, 0);
        rd(4);  check("oneshot_counter", readdata, 5);
        wr(0, 0);
        check("oneshot_irq_clear", {31'b0, irq}, 0);

        // Continuous with prescale on ch1
        wr(10, 3);
        wr(13, 2);
        wr(9, 32'h7);
        n = 0;
        while (!irq_vec[1] && n < 40) begin idle(); n++; end
        check("cont_first", n, 12);
        wr(8, 0);
        check("cont_cleared", {31'b0, irq_vec[1]}, 0);
        n = 1;
        while (!irq_vec[1] && n < 40) begin idle(); n++; end
        check("cont_spacing", n, 12);
        wr(8, 0);
        for (int i = 0; i < 10; i++) idle();
        wr(8, 0);
        check("cont_set_wins", {31'b0, irq_vec[1]}, 1);
        rd(8);  check("cont_status", readdata, 3);
        wr(9, 32'h8);
        wr(8, 0);

        // PERIOD write mid-count on ch0
        wr(2, 40);
        wr(1, 32'h4);
        for (int i = 0; i < 20; i++) idle();
        wr(2, 100);
        rd(0);  check("period_stops", readdata, 0);
        wr(4, 0);
        rd(4);  check("period_snap", readdata, 100);
        wr(1, 32'hC);
        rd(0);  check("start_wins", readdata, 2);
        rd(1);  check("ctrl_strobes", readdata, 0);
        wr(1, 32'h8);

        // PWM on ch2
        wr(18, 9);
        wr(19, 4);
        wr(17, 32'h16);
        for (int i = 0; i < 5; i++) idle();
        hi = 0;
        for (int i = 0; i < 40; i++) begin idle(); hi += int'(pwm_out[2]); end
        check("pwm_duty", hi, 16);
        wr(19, 0);
        idle(); idle();
        hi = 0;
        for (int i = 0; i < 20; i++) begin idle(); hi += int'(pwm_out[2]); end
        check("pwm_cmp0", hi, 0);
        wr(17, 32'h8);

        // Addressing and width masking
        wr(26, 7);
        rd(26); check("ch3_read", readdata, 0);
        rd(6);  check("reg6_read", readdata, 0);
        rd(2);  check("ch0_untouched", readdata, 100);
        rd(18); check("ch2_untouched", readdata, 9);
        rd(10); check("ch1_untouched", readdata, 3);
        wr(2, 32'h0001_0007);
        rd(2);  check("period_mask", readdata, 7);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned a = $urandom_range(0, 31);
            logic [31:0] d;
            case (a & 7)
                2: d = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 20);
                3: d = $urandom_range(0, 25);
                5: d = $urandom_range(0, 3);
                1: d = $urandom_range(0, 31);
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 299) == 0) step(1, 0, 1, a, d);
            else if ($urandom_range(0, 9) < 3) step(0, 1, 0, a, d);
            else step(0, $urandom_range(0, 1), 1, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
